// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Single-clock FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//
// Ports
//   clock         sole clock, rising edge
//   reset         synchronous, active-high; highest priority
//   flush         synchronous empty request; clears pointers, count, flags
//   wr_en/wr_data write request and data
//   rd_en         read request
//   rd_data       registered read data, held when no read is accepted
//   rd_valid      high for the cycle after each accepted read
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         number of stored entries
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//
// Handshake: wr_en is the writer's valid and !full is its ready; rd_en is the
// reader's valid and !empty is its ready. A transfer happens on a rising edge
// only when valid and ready are both high at that edge. full/empty are
// sampled before the edge, so a read never frees space for a same-edge write.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags are decodes of the registered count, so they change only
  // one edge after the operation that moved the count.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage is not reset; reset/flush only move the pointers, which is
  // enough to discard whatever the array still holds.
  always_ff @(posedge clock) begin
    if (!reset && !flush && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // rd_data deliberately keeps its last value across a flush.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural rollover.
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      rd_valid <= rd_acc;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ST_W   = CNT_W + 7 + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  always #5 clock = ~clock;

  param_sync_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  logic [ST_W-1:0] act;
  assign act = {count, full, empty, almost_full, almost_empty,
                overflow, underflow, rd_valid, rd_data};

  // Every output after a reset edge, with count 0 and AE=2, AF=6.
  localparam logic [ST_W-1:0] RESET_ST = {4'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                                          1'b0, 1'b0, 1'b0, 8'h00};

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_rd_data  = '0;
  logic              m_rd_valid = 1'b0;
  logic              m_ov       = 1'b0;
  logic              m_un       = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic logic [ST_W-1:0] exp_status();
    int n;
    n = exp_q.size();
    return {CNT_W'(n), (n == DEPTH), (n == 0), (n >= AF), (n <= AE),
            m_ov, m_un, m_rd_valid, m_rd_data};
  endfunction

  // Driver: apply inputs, clock one edge, advance the model using the
  // pre-edge occupancy, then settle 1 time unit past the edge.
  task automatic step(input logic rst, input logic fl, input logic we,
                      input logic re, input logic [DATA_W-1:0] wd);
    int  n;
    bit  was_full;
    bit  was_empty;
    reset = rst; flush = fl; wr_en = we; rd_en = re; wr_data = wd;
    @(posedge clock);
    n = exp_q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (rst) begin
      exp_q.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else if (fl) begin
      exp_q.delete();
      m_rd_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      m_rd_valid = 1'b0;
      if (re && !was_empty) begin
        m_rd_data  = exp_q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (we && !was_full) exp_q.push_back(wd);
      if (we && was_full)  m_ov = 1'b1;
      if (re && was_empty) m_un = 1'b1;
    end
    #1;
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1, 0, 0, 0, 8'h00);
    total++;
    if (act !== RESET_ST) begin
      bad++; $display("FAIL reset_state act=%h exp=%h", act, RESET_ST);
    end
  endtask

  task automatic test_fill_drain();
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 1, 0, DATA_W'(i));
      total++;
      if (act !== exp_status()) begin
        bad++; $display("FAIL fill_%0d act=%h exp=%h", i, act, exp_status());
      end
    end
    total++;
    if (full !== 1'b1 || count !== CNT_W'(8)) begin
      bad++; $display("FAIL fill_full full=%b count=%0d exp full=1 count=8", full, count);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 0, 0, 1, 8'h00);
      total++;
      if (rd_data !== DATA_W'(i) || rd_valid !== 1'b1) begin
        bad++; $display("FAIL drain_%0d rd_data=%h rd_valid=%b exp %h/1", i, rd_data, rd_valid, DATA_W'(i));
      end
    end
    total++;
    if (empty !== 1'b1 || act !== exp_status()) begin
      bad++; $display("FAIL drain_empty act=%h exp=%h", act, exp_status());
    end
  endtask

  task automatic test_full_rw();
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= DEPTH; i++) step(0, 0, 1, 0, DATA_W'(i));
    step(0, 0, 1, 1, 8'hAA);
    total++;
    if (count !== CNT_W'(7) || overflow !== 1'b1 || rd_data !== 8'h01) begin
      bad++; $display("FAIL full_rw count=%0d ov=%b rd_data=%h exp 7/1/01", count, overflow, rd_data);
    end
    // Drain: 0xAA must never come out.
    for (int i = 2; i <= DEPTH; i++) begin
      step(0, 0, 0, 1, 8'h00);
      total++;
      if (rd_data !== DATA_W'(i) || act !== exp_status()) begin
        bad++; $display("FAIL full_rw_drain_%0d act=%h exp=%h", i, act, exp_status());
      end
    end
  endtask

  task automatic test_empty_rw();
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 1, 8'h55);
    total++;
    if (count !== CNT_W'(1) || underflow !== 1'b1 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL empty_rw count=%0d un=%b rv=%b exp 1/1/0", count, underflow, rd_valid);
    end
    step(0, 0, 0, 1, 8'h00);
    total++;
    if (rd_data !== 8'h55 || rd_valid !== 1'b1 || act !== exp_status()) begin
      bad++; $display("FAIL empty_rw_read act=%h exp=%h", act, exp_status());
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] d;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, DATA_W'(i));
    nxt = 8'h01;
    d   = 8'h05;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 1, d);
      d++;
      total++;
      if (count !== CNT_W'(4) || rd_data !== nxt || act !== exp_status()) begin
        bad++; $display("FAIL wrap_%0d act=%h exp=%h next_word=%h", i, act, exp_status(), nxt);
      end
      nxt++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 8'h00);
      total++;
      if (rd_data !== nxt) begin
        bad++; $display("FAIL wrap_drain_%0d rd_data=%h exp=%h", i, rd_data, nxt);
      end
      nxt++;
    end
  endtask

  task automatic test_thresholds();
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h12);
    total++;
    if (almost_empty !== 1'b1) begin
      bad++; $display("FAIL ae_at_2 almost_empty=%b exp=1", almost_empty);
    end
    step(0, 0, 1, 0, 8'h13);
    total++;
    if (almost_empty !== 1'b0) begin
      bad++; $display("FAIL ae_at_3 almost_empty=%b exp=0", almost_empty);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h20);
    total++;
    if (almost_full !== 1'b1 || count !== CNT_W'(6)) begin
      bad++; $display("FAIL af_at_6 almost_full=%b count=%0d exp 1/6", almost_full, count);
    end
    step(0, 0, 0, 1, 8'h00);
    total++;
    if (almost_full !== 1'b0 || count !== CNT_W'(5)) begin
      bad++; $display("FAIL af_at_5 almost_full=%b count=%0d exp 0/5", almost_full, count);
    end
  endtask

  task automatic test_flush();
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, DATA_W'(8'h10 + i));
    step(0, 0, 1, 0, 8'hEE);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00);
    total++;
    if (count !== CNT_W'(5) || overflow !== 1'b1 || rd_data !== 8'h12) begin
      bad++; $display("FAIL flush_pre count=%0d ov=%b rd_data=%h exp 5/1/12", count, overflow, rd_data);
    end
    step(0, 1, 1, 1, 8'h77);
    total++;
    if (count !== CNT_W'(0) || empty !== 1'b1 || overflow !== 1'b0 ||
        rd_data !== 8'h12 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL flush_post act=%h exp count=0 empty=1 ov=0 rd_data=12 rv=0", act);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h30);
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 1, 1, 8'h99);
    total++;
    if (act !== RESET_ST) begin
      bad++; $display("FAIL reset_midop act=%h exp=%h", act, RESET_ST);
    end
  endtask

  task automatic test_random();
    logic rst;
    logic fl;
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      step(rst, fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DATA_W'($urandom));
      total++;
      if (act !== exp_status()) begin
        bad++; $display("FAIL random_%0d act=%h exp=%h", i, act, exp_status());
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_thresholds();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
